// File: rtl/shifter_pkg.sv
// Shared constants for the ALU shift/scale stage.
package shifter_pkg;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam int unsigned ALU_WIDTH = 8;

endpackage

// File: rtl/shifter.sv
// Parallel-load, bidirectional logical shift register with zero fill.
// Reset beats load, load beats shift; y is the register itself.
module shifter
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dir,
   input  logic             inp,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] r_q, r_d;

   function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] cur,
                                                   input logic             d,
                                                   input logic             ld,
                                                   input logic [WIDTH-1:0] din);
      if (ld) begin
         return din;
      end else if (d == DIR_LEFT) begin
         return {cur[WIDTH-2:0], 1'b0};
      end else begin
         return {1'b0, cur[WIDTH-1:1]};
      end
   endfunction

   always_comb begin
      r_d = shift_next(r_q, dir, inp, a);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= r_d;
      end
   end

   assign y = r_q;

endmodule

// File: tb/tb_shifter.sv
// Directed plus random checks of shifter at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_shifter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        dir = 1'b0;
   logic        inp = 1'b0;
   logic [7:0]  a8  = '0;
   logic [15:0] a16 = '0;
   logic [7:0]  y8;
   logic [15:0] y16;

   int unsigned m8  = 0;
   int unsigned m16 = 0;
   int          total  = 0;
   int          passes = 0;

   shifter #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .dir (dir),
      .inp (inp),
      .a   (a8),
      .y   (y8)
   );

   shifter #(.WIDTH(16)) dut16 (
      .clk (clk),
      .rst (rst),
      .dir (dir),
      .inp (inp),
      .a   (a16),
      .y   (y16)
   );

   always #5 clk = ~clk;

   // Reference: shifting left doubles modulo 2^w, shifting right halves.
   function automatic int unsigned model_next(input int unsigned cur, input bit r, input bit i,
                                              input bit d, input int unsigned av,
                                              input int unsigned w);
      if (r) return 0;
      if (i) return av;
      if (d) return cur / 2;
      return (cur * 2) % (32'd1 << w);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drive inputs, take one edge, advance the model, compare both instances.
   task automatic step(input bit r_, input bit i_, input bit d_, input logic [7:0] av8,
                       input logic [15:0] av16);
      rst = r_;
      inp = i_;
      dir = d_;
      a8  = av8;
      a16 = av16;
      @(posedge clk);
      #1;
      m8  = model_next(m8, r_, i_, d_, int'(av8), 8);
      m16 = model_next(m16, r_, i_, d_, int'(av16), 16);
      chk("model8", {8'h00, y8}, m8[15:0]);
      chk("model16", y16, m16[15:0]);
   endtask

   initial begin
      // Reset beats load
      step(1, 1, 0, 8'hFF, 16'hFFFF);
      chk("reset", {8'h00, y8}, 16'h0000);

      // Left shift sequence
      step(0, 1, 0, 8'b10101010, 16'h0000);
      chk("left_load", {8'h00, y8}, 16'h00AA);
      step(0, 0, 0, 8'h00, 16'h0000);
      chk("left_1", {8'h00, y8}, 16'h0054);
      step(0, 0, 0, 8'h00, 16'h0000);
      chk("left_2", {8'h00, y8}, 16'h00A8);
      step(0, 0, 0, 8'h00, 16'h0000);
      chk("left_3", {8'h00, y8}, 16'h0050);
      step(0, 0, 0, 8'h00, 16'h0000);
      chk("left_4", {8'h00, y8}, 16'h00A0);

      // Right shift sequence
      step(0, 1, 1, 8'b11001101, 16'h0000);
      chk("right_load", {8'h00, y8}, 16'h00CD);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, 16'h0000);
      chk("right_4", {8'h00, y8}, 16'h000C);

      // Drain and saturation
      step(0, 1, 0, 8'h80, 16'h0000);
      step(0, 0, 0, 8'h00, 16'h0000);
      chk("drain_left", {8'h00, y8}, 16'h0000);
      step(0, 0, 0, 8'h00, 16'h0000);
      step(0, 0, 1, 8'h00, 16'h0000);
      chk("drain_stay", {8'h00, y8}, 16'h0000);
      step(0, 1, 1, 8'h01, 16'h0000);
      step(0, 0, 1, 8'h00, 16'h0000);
      chk("drain_right", {8'h00, y8}, 16'h0000);

      // Mid-sequence direction change, reload and reset
      step(0, 1, 0, 8'hF0, 16'h0000);
      step(0, 0, 0, 8'h00, 16'h0000);
      chk("mid_left", {8'h00, y8}, 16'h00E0);
      step(0, 0, 1, 8'h00, 16'h0000);
      chk("mid_right", {8'h00, y8}, 16'h0070);
      step(0, 1, 0, 8'h3C, 16'h0000);
      chk("mid_reload", {8'h00, y8}, 16'h003C);
      step(1, 0, 0, 8'h00, 16'h0000);
      chk("mid_reset", {8'h00, y8}, 16'h0000);

      // Wide instance
      step(0, 1, 1, 8'h00, 16'h8001);
      step(0, 0, 1, 8'h00, 16'h0000);
      chk("wide_right", y16, 16'h4000);
      step(0, 1, 0, 8'h00, 16'h8001);
      step(0, 0, 0, 8'h00, 16'h0000);
      chk("wide_left", y16, 16'h0002);

      // Random traffic with occasional reset and frequent loads
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
              8'($urandom), 16'($urandom));
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
